// File: rtl/divider_16b_seq_if.sv
// Handshake and operand/result bundle for the sequential 16/9 signed divider.
// The master issues start with operands; the slave answers with busy/done and results.
interface divider_16b_seq_if;
  logic                start;
  logic signed [15:0]  dividend;
  logic signed [8:0]   divisor;
  logic                busy;
  logic                done;
  logic signed [6:0]   quotient;
  logic signed [8:0]   remainder;
  logic                overflow;
  logic                div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, overflow, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, overflow, div_zero
  );
endinterface

// File: rtl/divider_16b_seq.sv
// Radix-2 restoring signed divider: 16-bit dividend / 9-bit divisor -> 7-bit
// saturated quotient and 9-bit remainder, one quotient bit per clock on magnitudes.
module divider_16b_seq (
  input  logic             clk,
  input  logic             reset_n,
  divider_16b_seq_if.slave bus
);
  localparam int DATA_W = 16;
  localparam int COEF_W = 9;
  localparam int QUO_W  = 7;

  localparam logic signed [DATA_W:0] QUO_MAX = 17'sd63;
  localparam logic signed [DATA_W:0] QUO_MIN = -17'sd64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic              accept;
  logic              step;
  logic              load;
  logic [3:0]        iter;

  logic              sd;
  logic              sv;
  logic              zero_div;
  logic [DATA_W-1:0] dmag;
  logic [COEF_W-1:0] vmag;
  logic [COEF_W-1:0] prem;
  logic [DATA_W-1:0] qmag;

  logic [COEF_W:0]   pr_shift;
  logic              q_bit;

  logic signed [DATA_W:0]   q_signed;
  logic [QUO_W:0]           q_sat;
  logic signed [COEF_W-1:0] rem_fix;

  logic                     res_done;
  logic signed [QUO_W-1:0]  res_quo;
  logic signed [COEF_W-1:0] res_rem;
  logic                     res_ovf;
  logic                     res_dz;

  function automatic logic [DATA_W-1:0] mag_dividend(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  function automatic logic [COEF_W-1:0] mag_divisor(input logic signed [COEF_W-1:0] x);
    return x[COEF_W-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  // Returns {overflow, quotient}; out-of-range values clamp to the nearest limit.
  function automatic logic [QUO_W:0] sat_quo(input logic signed [DATA_W:0] q);
    if (q > QUO_MAX)
      return {1'b1, 7'h3f};
    else if (q < QUO_MIN)
      return {1'b1, 7'h40};
    else
      return {1'b0, QUO_W'(q)};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (bus.divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (iter == 4'd15)
          state_nxt = FIX;
      end
      FIX: begin
        load      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration stage: shift in the next dividend bit and try a subtraction.
  assign pr_shift = {prem, dmag[DATA_W-1]};
  assign q_bit    = (pr_shift >= {1'b0, vmag});

  always_ff @(posedge clk) begin
    if (accept) begin
      sd       <= bus.dividend[DATA_W-1];
      sv       <= bus.divisor[COEF_W-1];
      zero_div <= (bus.divisor == '0);
      dmag     <= mag_dividend(bus.dividend);
      vmag     <= mag_divisor(bus.divisor);
      prem     <= '0;
      qmag     <= '0;
    end else if (step) begin
      dmag <= {dmag[DATA_W-2:0], 1'b0};
      prem <= q_bit ? COEF_W'(pr_shift - {1'b0, vmag}) : COEF_W'(pr_shift);
      qmag <= {qmag[DATA_W-2:0], q_bit};
    end
  end

  // Fix stage: restore signs, saturate the quotient into its 7-bit range.
  assign q_signed = (sd ^ sv) ? -$signed({1'b0, qmag}) : $signed({1'b0, qmag});
  assign q_sat    = sat_quo(q_signed);
  assign rem_fix  = sd ? -$signed(prem) : $signed(prem);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iter     <= '0;
      res_done <= 1'b0;
      res_quo  <= '0;
      res_rem  <= '0;
      res_ovf  <= 1'b0;
      res_dz   <= 1'b0;
    end else begin
      res_done <= load;
      if (accept)
        iter <= '0;
      else if (step)
        iter <= iter + 4'd1;
      if (load) begin
        if (zero_div) begin
          res_quo <= sd ? 7'sh40 : 7'sh3f;
          res_rem <= '0;
          res_ovf <= 1'b1;
          res_dz  <= 1'b1;
        end else begin
          {res_ovf, res_quo} <= q_sat;
          res_rem <= rem_fix;
          res_dz  <= 1'b0;
        end
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = res_done;
  assign bus.quotient  = res_quo;
  assign bus.remainder = res_rem;
  assign bus.overflow  = res_ovf;
  assign bus.div_zero  = res_dz;

endmodule

// File: doc/divider_16b_seq.md
# divider_16b_seq

Sequential signed divider that inverts the `multiplier_16b` operation: it takes a 16-bit two's-complement dividend (product width) and a 9-bit two's-complement divisor (`in2` width), and returns a 7-bit quotient (`in1` width) plus a 9-bit remainder. It is a radix-2 restoring divider running on sign-magnitude operands, one quotient bit per clock, with a start/busy/done handshake. It is used to check multiplier results and to recover one factor from a product.

## Interface
- Parameters: none. Widths are fixed at 16/9/7/9 to match `multiplier_16b`.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request. Sampled only when `busy`=0.
- `dividend` input 16: signed dividend. Captured on the accepting edge.
- `divisor` input 9: signed divisor. Captured on the accepting edge.
- `busy` output 1: high from the edge after acceptance until the result edge.
- `done` output 1: one-cycle pulse; results are valid from this cycle.
- `quotient` output 7: signed quotient, truncated toward zero, saturated.
- `remainder` output 9: signed remainder; its sign follows the dividend.
- `overflow` output 1: true quotient lies outside [-64, 63].
- `div_zero` output 1: divisor was 0.

## Operation
- States:
  - IDLE: `busy`=0. Moves to CALC on `start`.
  - CALC: 16 iterations.
  - FIX: sign correction, saturation, and output register load. Returns to IDLE.
- Acceptance (IDLE, `start`=1):
  - Store `sd` = dividend[15] and `sv` = divisor[8].
  - Store the dividend magnitude (16-bit unsigned; `16'h8000` gives 32768) and the divisor magnitude (9-bit unsigned, up to 256).
  - Clear the 10-bit partial remainder and the iteration counter.
- Divide by zero at acceptance:
  - Skip CALC and go to FIX directly.
  - Result: `div_zero`=1, `overflow`=1, `remainder`=0.
  - `quotient` = 7'h3f if `sd`=0, else 7'h40.
- CALC iteration (one per edge):
  - Shift the partial remainder left, bringing in the next dividend magnitude MSB.
  - If the partial remainder is ≥ the divisor magnitude: subtract it and set the quotient bit to 1. Otherwise set the quotient bit to 0.
  - The 16-bit quotient magnitude is built MSB first.
  - 4-bit counter. Go to FIX after the iteration with counter = 15.
- FIX:
  - Quotient sign = `sd` XOR `sv`. Negate the magnitude if negative (17-bit signed intermediate).
  - If the intermediate is > 63, output 7'h3f with `overflow`=1. If < -64, output 7'h40 with `overflow`=1. Otherwise output the low 7 bits with `overflow`=0.
  - `remainder` = the partial remainder magnitude (< 256), negated if `sd`=1, as 9 bits.
  - `div_zero`=0 on this path.
- Outputs `quotient`, `remainder`, `overflow` and `div_zero` are registered. They hold until the next FIX load, and do not change on acceptance.
- `start` is ignored while `busy`=1. Inputs are not re-sampled during CALC.

## Timing
- Reset values:
  - State IDLE; `busy`=0, `done`=0.
  - `quotient`=0, `remainder`=0, `overflow`=0, `div_zero`=0.
- Normal latency:
  - Accepting edge E0. CALC runs on edges E1..E16. FIX registers results on E17.
  - `done`=1 for the cycle after E17. `busy`=1 for the cycles after E0 through E16.
  - Total: 17 cycles from acceptance to `done`.
- Divide-by-zero latency: results and `done` appear on E1; `busy` stays high for one cycle.
- Back-to-back: `busy`=0 in the `done` cycle, so `start` can be accepted there. The next result follows 17 cycles later.
- Reset mid-operation: asserting `reset_n` low forces reset values immediately; the operation is discarded with no `done`. After deassertion the block waits for a fresh `start`.
- `done` never stays high for two consecutive cycles.

## Test plan
- 16'h0001 / 9'h1ff → `quotient` 7'h7f, `remainder` 9'h000, `overflow`=0, `done` 17 cycles after `start`.
- 16'hffc1 (-63) / 9'h1ff → 7'h3f, 9'h000. Also 16'h00a2 (162) / 9'h1af (-81) → 7'h7e, 9'h000. Together these are the round-trip of `multiplier_16b` vectors.
- 16'h0064 / 9'h007 → 7'h0e, 9'h002. Also 16'hff9c / 9'h007 → 7'h72, 9'h1fe (-2).
- 16'h1000 / 9'h001 → 7'h3f with `overflow`=1. Also 16'h8000 / 9'h1ff → 7'h3f with `overflow`=1.
- 16'hff00 / 9'h000 → `div_zero`=1, `overflow`=1, 7'h40, `remainder` 0, `done` on the second cycle.
- `start` pulsed during CALC is ignored. `start` held through the `done` cycle launches a second operation. `reset_n` low at iteration 8 → all outputs 0, no `done`.
